// File: rtl/sched_select_if.sv
// Event and schedule bus between the event source, sched_select and the downstream scheduler.
// An event transfers on a rising edge with ev && ev_ready; a schedule transfers on a rising edge with tx && tx_ack.
interface sched_select_if #(
    parameter int CTX_W = 32,
    parameter int OUT_W = 32,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             ev;
    logic [CTX_W-1:0] ev_context;
    logic             ev_ready;
    logic             tx;
    logic [OUT_W-1:0] scheduleOut;
    logic             tx_ack;
    logic             err;
    logic [LVL_W-1:0] level;

    modport master (
        output ev, ev_context, tx_ack,
        input  ev_ready, tx, scheduleOut, err, level
    );

    modport slave (
        input  ev, ev_context, tx_ack,
        output ev_ready, tx, scheduleOut, err, level
    );
endinterface

// File: rtl/sched_select.sv
// Buffers event selector fields in a FIFO, decodes them one at a time and presents
// the resulting schedule ID under a tx/tx_ack handshake; invalid selectors pulse err.
module sched_select #(
    parameter int CTX_W     = 32,
    parameter int SEL_W     = 3,
    parameter int OUT_W     = 32,
    parameter int DEPTH     = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    sched_select_if.slave      bus,
    output logic [1:0]         o_dbg_state
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_fifo [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LVL_W-1:0] r_level;
    logic [SEL_W-1:0] r_dec;
    logic             r_tx;
    logic             r_err;
    logic [OUT_W-1:0] r_sched;

    logic             w_push;
    logic             w_pop;
    logic             w_seen;
    logic             w_multi;
    logic             w_valid;
    logic [OUT_W-1:0] w_id;
    logic             w_tx_nxt;
    logic             w_err_nxt;
    logic [OUT_W-1:0] w_sched_nxt;

    assign bus.ev_ready    = (r_level != LVL_W'(DEPTH));
    assign bus.tx          = r_tx;
    assign bus.scheduleOut = r_sched;
    assign bus.err         = r_err;
    assign bus.level       = r_level;
    assign o_dbg_state     = r_state;

    assign w_push = bus.ev && bus.ev_ready;

    // Scanning low to high leaves w_id at the highest set bit.
    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        w_id    = '0;
        for (int k = 0; k < SEL_W; k++) begin
            if (r_dec[k]) begin
                if (w_seen) w_multi = 1'b1;
                w_seen = 1'b1;
                w_id   = OUT_W'(k + 1);
            end
        end
        w_valid = (PRIO_MODE == 0) ? (w_seen && !w_multi) : w_seen;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_sched_nxt = r_sched;
        w_err_nxt   = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (w_valid) begin
                    w_tx_nxt    = 1'b1;
                    w_sched_nxt = w_id;
                    w_state_nxt = PRESENT;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            PRESENT: begin
                if (bus.tx_ack) begin
                    w_tx_nxt    = 1'b0;
                    w_sched_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx    <= 1'b0;
            r_sched <= '0;
            r_err   <= 1'b0;
            r_dec   <= '0;
        end else begin
            r_tx    <= w_tx_nxt;
            r_sched <= w_sched_nxt;
            r_err   <= w_err_nxt;
            if (w_pop) r_dec <= r_fifo[r_rptr];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
            else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) r_fifo[r_wptr] <= bus.ev_context[CTX_W-1 -: SEL_W];
    end
endmodule

// File: tb/tb_sched_select.sv
// Drives one stimulus stream into a strict one-hot instance and a highest-bit-wins instance
// and scores each against an arithmetic model of the selector decode.
module tb_sched_select;
    localparam int CTX_W = 32;
    localparam int SEL_W = 3;
    localparam int OUT_W = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] ERR_TOK = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        ev;
    logic [31:0] ctx;
    logic        tx_ack;
    logic [1:0]  dbg0;
    logic [1:0]  dbg1;

    int n_tests;
    int n_fail;
    int n_tx [2];
    int n_err[2];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic        prev_tx [2];
    logic [31:0] prev_so [2];
    logic        prev_ack[2];

    sched_select_if #(.CTX_W(CTX_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus0 ();
    sched_select_if #(.CTX_W(CTX_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus1 ();

    assign bus0.ev = ev;
    assign bus0.ev_context = ctx;
    assign bus0.tx_ack = tx_ack;
    assign bus1.ev = ev;
    assign bus1.ev_context = ctx;
    assign bus1.tx_ack = tx_ack;

    sched_select #(.CTX_W(CTX_W), .SEL_W(SEL_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .PRIO_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .o_dbg_state(dbg0)
    );
    sched_select #(.CTX_W(CTX_W), .SEL_W(SEL_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .PRIO_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .o_dbg_state(dbg1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: schedule ID, or ERR_TOK for a discarded selector
    function automatic logic [31:0] model_id(input logic [2:0] f, input int mode);
        int unsigned v;
        v = 32'(f);
        if (v == 0) return ERR_TOK;
        if (mode == 0) begin
            if ((v & (v - 1)) != 0) return ERR_TOK;
            return 32'($clog2(v) + 1);
        end
        return 32'($clog2(v + 1));
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // scoreboard
    task automatic pop_cmp(input int d, input string name, input logic [31:0] act);
        logic [31:0] e;
        int sz;
        sz = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_dut%0d: got %0h, expected no output (nothing queued)", name, d, act);
        end else begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check($sformatf("%s_dut%0d", name, d), act, e);
        end
    endtask

    task automatic mon(input int d, input logic t, input logic [31:0] so, input logic e);
        if (prev_tx[d] && !prev_ack[d]) begin
            check($sformatf("hold_tx_dut%0d", d), 32'(t), 32'd1);
            check($sformatf("hold_id_dut%0d", d), so, prev_so[d]);
        end
        if (!t) check($sformatf("idle_id_dut%0d", d), so, 32'd0);
        if (t && tx_ack) begin
            pop_cmp(d, "schedule", so);
            n_tx[d]++;
        end
        if (e) begin
            pop_cmp(d, "discard", ERR_TOK);
            n_err[d]++;
        end
        prev_tx[d]  = t;
        prev_so[d]  = so;
        prev_ack[d] = tx_ack;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0, bus0.tx, bus0.scheduleOut, bus0.err);
            mon(1, bus1.tx, bus1.scheduleOut, bus1.err);
            if (ev && bus0.ev_ready) exp_q0.push_back(model_id(ctx[31:29], 0));
            if (ev && bus1.ev_ready) exp_q1.push_back(model_id(ctx[31:29], 1));
        end else begin
            prev_tx[0] = 1'b0;
            prev_tx[1] = 1'b0;
        end
    end

    // driver tasks
    task automatic step(input logic e, input logic [2:0] f, input logic a);
        ev     = e;
        ctx    = {f, 29'($urandom)};
        tx_ack = a;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] onehot();
        logic [2:0] v;
        v = 3'b001 << $urandom_range(0, 2);
        return v;
    endfunction

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && bus0.level == 0 && bus1.level == 0 &&
                !bus0.tx && !bus1.tx && dbg0 == 2'd0 && dbg1 == 2'd0 && !bus0.err && !bus1.err) begin
                done = 1'b1;
                break;
            end
            step(1'b0, 3'b000, 1'b1);
        end
        check({name, "_drained"}, 32'(done), 32'd1);
    endtask

    task automatic chk_both(input string name, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] e);
        check({name, "_dut0"}, a0, e);
        check({name, "_dut1"}, a1, e);
    endtask

    int t0, t1, e0, e1;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int d = 0; d < 2; d++) begin
            n_tx[d] = 0; n_err[d] = 0; prev_tx[d] = 1'b0; prev_so[d] = '0; prev_ack[d] = 1'b0;
        end
        rst = 1'b0; ev = 1'b0; ctx = '0; tx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_both("rst_level", 32'(bus0.level), 32'(bus1.level), 32'd0);
        chk_both("rst_ev_ready", 32'(bus0.ev_ready), 32'(bus1.ev_ready), 32'd1);
        chk_both("rst_tx", 32'(bus0.tx), 32'(bus1.tx), 32'd0);
        chk_both("rst_id", bus0.scheduleOut, bus1.scheduleOut, 32'd0);
        chk_both("rst_err", 32'(bus0.err), 32'(bus1.err), 32'd0);
        chk_both("rst_state", 32'(dbg0), 32'(dbg1), 32'd0);
        rst = 1'b1;

        // single event latency: accepted at edge N, tx after edge N+2
        step(1'b1, 3'b001, 1'b1);
        chk_both("lat_n_level", 32'(bus0.level), 32'(bus1.level), 32'd1);
        chk_both("lat_n_tx", 32'(bus0.tx), 32'(bus1.tx), 32'd0);
        step(1'b0, 3'b000, 1'b1);
        chk_both("lat_n1_tx", 32'(bus0.tx), 32'(bus1.tx), 32'd0);
        chk_both("lat_n1_state", 32'(dbg0), 32'(dbg1), 32'd1);
        step(1'b0, 3'b000, 1'b1);
        chk_both("lat_n2_tx", 32'(bus0.tx), 32'(bus1.tx), 32'd1);
        chk_both("lat_n2_id", bus0.scheduleOut, bus1.scheduleOut, 32'd1);
        step(1'b0, 3'b000, 1'b1);
        chk_both("lat_n3_tx", 32'(bus0.tx), 32'(bus1.tx), 32'd0);
        chk_both("lat_n3_level", 32'(bus0.level), 32'(bus1.level), 32'd0);
        drain("latency");

        // back-to-back selectors with mixed validity
        t0 = n_tx[0]; t1 = n_tx[1]; e0 = n_err[0]; e1 = n_err[1];
        step(1'b1, 3'b010, 1'b1);
        step(1'b1, 3'b100, 1'b1);
        step(1'b1, 3'b011, 1'b1);
        step(1'b1, 3'b000, 1'b1);
        drain("mixed");
        check("mixed_tx_dut0", 32'(n_tx[0] - t0), 32'd2);
        check("mixed_err_dut0", 32'(n_err[0] - e0), 32'd2);
        check("mixed_tx_dut1", 32'(n_tx[1] - t1), 32'd3);
        check("mixed_err_dut1", 32'(n_err[1] - e1), 32'd1);

        // multi-bit selectors
        t0 = n_tx[0]; t1 = n_tx[1]; e0 = n_err[0]; e1 = n_err[1];
        step(1'b1, 3'b011, 1'b1);
        step(1'b1, 3'b110, 1'b1);
        drain("multibit");
        check("multibit_tx_dut0", 32'(n_tx[0] - t0), 32'd0);
        check("multibit_err_dut0", 32'(n_err[0] - e0), 32'd2);
        check("multibit_tx_dut1", 32'(n_tx[1] - t1), 32'd2);
        check("multibit_err_dut1", 32'(n_err[1] - e1), 32'd0);

        // saturation with downstream stalled
        t0 = n_tx[0]; t1 = n_tx[1];
        for (int i = 0; i < 8; i++) step(1'b1, onehot(), 1'b0);
        chk_both("sat_level", 32'(bus0.level), 32'(bus1.level), 32'(DEPTH));
        chk_both("sat_ev_ready", 32'(bus0.ev_ready), 32'(bus1.ev_ready), 32'd0);
        chk_both("sat_tx", 32'(bus0.tx), 32'(bus1.tx), 32'd1);
        drain("sat");
        check("sat_count_dut0", 32'(n_tx[0] - t0), 32'(DEPTH + 1));
        check("sat_count_dut1", 32'(n_tx[1] - t1), 32'(DEPTH + 1));

        // push on the same edge as a pop at level DEPTH-1
        for (int i = 0; i < 4; i++) step(1'b1, onehot(), 1'b0);
        chk_both("pp_pre_level", 32'(bus0.level), 32'(bus1.level), 32'(DEPTH - 1));
        chk_both("pp_pre_tx", 32'(bus0.tx), 32'(bus1.tx), 32'd1);
        step(1'b0, 3'b000, 1'b1);
        chk_both("pp_ack_tx", 32'(bus0.tx), 32'(bus1.tx), 32'd0);
        step(1'b1, onehot(), 1'b0);
        chk_both("pp_level", 32'(bus0.level), 32'(bus1.level), 32'(DEPTH - 1));
        drain("pushpop");

        // random traffic, many pointer wraps
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
        drain("random");

        // reset while presenting with entries queued
        for (int i = 0; i < 3; i++) step(1'b1, onehot(), 1'b0);
        step(1'b0, 3'b000, 1'b0);
        chk_both("mid_pre_tx", 32'(bus0.tx), 32'(bus1.tx), 32'd1);
        chk_both("mid_pre_level", 32'(bus0.level), 32'(bus1.level), 32'd2);
        rst = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        step(1'b1, 3'b001, 1'b1);
        chk_both("mid_rst_tx", 32'(bus0.tx), 32'(bus1.tx), 32'd0);
        chk_both("mid_rst_id", bus0.scheduleOut, bus1.scheduleOut, 32'd0);
        chk_both("mid_rst_level", 32'(bus0.level), 32'(bus1.level), 32'd0);
        chk_both("mid_rst_err", 32'(bus0.err), 32'(bus1.err), 32'd0);
        step(1'b1, 3'b001, 1'b1);
        chk_both("mid_rst_ev_ignored", 32'(bus0.level), 32'(bus1.level), 32'd0);
        rst = 1'b1;
        t0 = n_tx[0]; t1 = n_tx[1]; e0 = n_err[0]; e1 = n_err[1];
        for (int i = 0; i < 6; i++) step(1'b0, 3'b000, 1'b1);
        check("post_rst_tx_dut0", 32'(n_tx[0] - t0 + n_err[0] - e0), 32'd0);
        check("post_rst_tx_dut1", 32'(n_tx[1] - t1 + n_err[1] - e1), 32'd0);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sched_select.md
# sched_select

Parametrised event-to-schedule selector for the memory controller. Each accepted event carries a context word whose top SEL_W bits select a memory schedule. Events are buffered in a small FIFO, decoded one at a time, and presented as a schedule ID under a valid/ack handshake to the downstream scheduler. Invalid selectors are discarded and flagged. All logic runs on the rising edge only.

## Interface
- CTX_W, 32, context word width
- SEL_W, 3, selector field width, taken from context[CTX_W-1 -: SEL_W]; 1..CTX_W
- OUT_W, 32, scheduleOut width; must be at least clog2(SEL_W+1)
- DEPTH, 4, event FIFO depth; power of 2, at least 2
- PRIO_MODE, 0, 0 = strict one-hot selector; 1 = highest set bit wins

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-low reset
- ev  in  1  event strobe; accepted when ev && ev_ready
- context  in  CTX_W  context word, sampled with ev
- ev_ready  out  1  FIFO not full
- tx  out  1  schedule valid
- scheduleOut  out  OUT_W  schedule ID (1..SEL_W); 0 whenever tx=0
- tx_ack  in  1  downstream accepts the presented schedule
- err  out  1  one-cycle pulse when an entry is discarded as invalid
- level  out  clog2(DEPTH+1)  current FIFO occupancy

## Operation
- **FIFO**
  - Stores the SEL_W selector field only; the rest of the context is ignored.
  - Push on ev && ev_ready.
  - ev_ready = (level != DEPTH), computed from the registered level. A pop in the same cycle does not free space for a push in that cycle.
  - ev while full is ignored: no push, no error, level unchanged.
  - Pointers wrap modulo DEPTH.
- **Decode** of selector f:
  - PRIO_MODE=0: valid only if exactly one bit of f is set, at bit k; ID = k+1.
  - PRIO_MODE=1: valid if f != 0; k = index of the highest set bit; ID = k+1.
  - f == 0 is always invalid.
- **FSM** (encoded states IDLE, LOAD, PRESENT):
  - IDLE: if level != 0, copy the head into the decode register, pop, go to LOAD. Otherwise stay.
  - LOAD: if valid, set tx<=1, scheduleOut<=ID, go to PRESENT. If invalid, set err<=1 for one cycle and go to IDLE; tx stays 0.
  - PRESENT: hold tx=1 with scheduleOut stable. On tx_ack, set tx<=0, scheduleOut<=0, go to IDLE.
- tx_ack outside PRESENT is ignored.
- Push and pop in the same cycle leave level unchanged and both take effect.

## Timing
- **Reset** (rst=0 at a rising edge):
  - state=IDLE, FIFO empty, level=0, ev_ready=1, tx=0, scheduleOut=0, err=0.
  - Reset mid-operation aborts any presented schedule and drops all queued entries with no err pulse.
  - ev is ignored while rst=0.
- **Latency:** an event accepted at edge N into an empty, idle block gives tx=1 after edge N+2.
- **Throughput:** at most one schedule per 3 cycles (ack edge → IDLE → LOAD → PRESENT).
- **Invalid entry:** err is high for exactly the one cycle after the LOAD edge. The next entry, if present, is popped on the following edge.
- tx and scheduleOut change only on LOAD→PRESENT and PRESENT→IDLE transitions.
- All outputs are registered except ev_ready, which is decoded from the registered level.

## Test plan
- Reset, then ev=1 for one cycle with context=32'h2000_0000 (f=001), tx_ack tied 1 -> tx=1 and scheduleOut=1 for one cycle, 2 edges after acceptance; level returns to 0.
- PRIO_MODE=0: push f=010, 100, 011, 000 back-to-back with tx_ack=1 -> scheduleOut 2, then 3, then err pulses twice with no tx; exactly 2 tx pulses total.
- PRIO_MODE=1: push f=011, then f=110 -> scheduleOut 2, then 3; err never asserts.
- tx_ack held 0, ev held 1 with valid contexts -> level saturates at DEPTH; ev_ready=0; extra events dropped; tx stays 1 with a stable ID. Then ack every cycle -> exactly DEPTH+1 schedules delivered in order (one popped + DEPTH queued).
- Push while the block is popping at level=DEPTH-1 -> level stays DEPTH-1; order preserved across pointer wrap over 3·DEPTH events.
- rst=0 asserted while tx=1 with 2 entries queued -> next cycle tx=0, scheduleOut=0, level=0, err=0; no stale schedule after release.
